// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter and its lane aligner.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  // Request fields latched at grant time
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    size_e       size;
    logic        is_unsigned;
  } req_t;

  localparam logic [1:0] SzIllegal = 2'b11;

  // Flags illegal size, misalignment, or a word index beyond the RAM
  function automatic logic req_error(input logic [31:0] addr, input size_e size,
                                     input int unsigned depth);
    logic err;
    err = 1'b0;
    if (2'(size) == SzIllegal) err = 1'b1;
    if (size == SZ_HALF && addr[0]) err = 1'b1;
    if (size == SZ_WORD && addr[1:0] != 2'b00) err = 1'b1;
    // Full addr[31:2] compare so high-bit aliases are rejected
    if ({2'b00, addr[31:2]} >= depth) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Store-lane merge and load lane extract/extend for a 32-bit little-endian word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  shift;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign shift     = {addr_lo, 3'b000};
  assign half_lane = addr_lo[1] ? word[31:16] : word[15:0];

  // Pick the addressed byte lane
  always_comb begin
    byte_lane = word[7:0];
    case (addr_lo)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
  end

  // Replace only the written lane so neighbouring bytes survive
  always_comb begin
    merged = wdata;
    case (size)
      SZ_BYTE: merged = (word & ~(32'h0000_00FF << shift)) |
                        ({24'h0, wdata[7:0]} << shift);
      SZ_HALF: merged = addr_lo[1] ? {wdata[15:0], word[15:0]}
                                   : {word[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
  end

  // Load result with sign or zero extension; words pass through
  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Two-port round-robin arbiter and sequencer for a single-port word RAM.
// Sub-word stores are performed as read-modify-write.
module dmem_arbiter_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [1:0]    m0_size,
  input  logic          m0_unsigned,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [1:0]    m1_size,
  input  logic          m1_unsigned,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic        id_q;
  req_t        req_q;
  logic        err_q;
  logic [31:0] word_q;

  logic        grant;
  logic        grant_id;
  req_t        cand;
  logic        cand_err;
  logic [AW-1:0] word_addr;
  logic [31:0] merged;
  logic [31:0] load_data;
  logic [31:0] resp_rdata;
  logic        unused_addr_hi;

  assign word_addr      = req_q.addr[AW+1:2];
  assign unused_addr_hi = ^req_q.addr[31:AW+2];

  // Round-robin pick and candidate request mux
  always_comb begin
    grant    = m0_req | m1_req;
    grant_id = (m0_req & m1_req) ? ~last_grant_q : m1_req;
    if (grant_id) begin
      cand = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, size: size_e'(m1_size),
               is_unsigned: m1_unsigned};
    end else begin
      cand = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, size: size_e'(m0_size),
               is_unsigned: m0_unsigned};
    end
    cand_err = req_error(cand.addr, cand.size, DEPTH);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          if (cand_err)                             state_d = RESP;
          else if (!cand.we || cand.size != SZ_WORD) state_d = RD;
          else                                      state_d = WR;
        end
      end
      RD:      state_d = req_q.we ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the granted request; inputs are not looked at again until IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      req_q        <= '0;
      err_q        <= 1'b0;
    end else if (state_q == IDLE && grant) begin
      last_grant_q <= grant_id;
      id_q         <= grant_id;
      req_q        <= cand;
      err_q        <= cand_err;
    end
  end

  // Capture the RAM word for loads and read-modify-write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           word_q <= '0;
    else if (state_q == RD) word_q <= mem_rdata;
  end

  dmem_lane_align u_lane_align (
    .word        (word_q),
    .wdata       (req_q.wdata),
    .addr_lo     (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .merged      (merged),
    .load_data   (load_data)
  );

  assign resp_rdata = (!req_q.we && !err_q) ? load_data : '0;

  // RAM strobes and requester responses decoded from state
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    m0_ready  = 1'b0;
    m0_err    = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_err    = 1'b0;
    m1_rdata  = '0;
    case (state_q)
      RD: mem_addr = word_addr;
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = merged;
      end
      RESP: begin
        if (id_q) begin
          m1_ready = 1'b1;
          m1_err   = err_q;
          m1_rdata = resp_rdata;
        end else begin
          m0_ready = 1'b1;
          m0_err   = err_q;
          m0_rdata = resp_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Self-checking bench: directed cases plus random traffic against a byte-array model.
module tb_dmem_arbiter_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_req, m0_we, m0_unsigned, m1_req, m1_we, m1_unsigned;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]    m0_size, m1_size;
  logic          m0_ready, m1_ready, m0_err, m1_err;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] ram [DEPTH] = '{default: 32'h0};
  logic [7:0]  ref_bytes [DEPTH*4] = '{default: 8'h0};
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_size     (m0_size),
    .m0_unsigned (m0_unsigned),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m0_err      (m0_err),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_size     (m1_size),
    .m1_unsigned (m1_unsigned),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .m1_err      (m1_err),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Word RAM: combinational read, clocked write
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input bit uns);
    if (port) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      m1_size = size; m1_unsigned = uns;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      m0_size = size; m0_unsigned = uns;
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  // Byte-level model of one access: error rules, memory effect, result, latency
  function automatic void ref_access(input bit we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [1:0] size,
                                     input bit uns, output bit err, output logic [31:0] rd,
                                     output int lat);
    int n;
    logic [31:0] v;
    n   = 1 << size;
    err = (size == 2'd3) || (addr % n != 0) || ((addr >> 2) >= DEPTH);
    rd  = '0;
    if (err) begin
      lat = 1;
      return;
    end
    if (we) begin
      for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = 8'(wdata >> (8*i));
      lat = (n == 4) ? 2 : 3;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      rd  = v;
      lat = 2;
    end
  endfunction

  // One transaction on an idle arbiter; starts and ends on a falling edge in IDLE
  task automatic txn(input bit port, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input bit uns);
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          lat = 0;
    int          we_cnt = 0;
    bit          got = 0;
    bit          other = 0;
    logic [31:0] rd_obs = '0;
    logic        err_obs = 1'b0;
    ref_access(we, addr, wdata, size, uns, exp_err, exp_rd, exp_lat);
    drive(port, 1'b1, we, addr, wdata, size, uns);
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_we) we_cnt++;
      if (port ? m0_ready : m1_ready) other = 1'b1;
      if (port ? m1_ready : m0_ready) begin
        got     = 1'b1;
        rd_obs  = port ? m1_rdata : m0_rdata;
        err_obs = port ? m1_err : m0_err;
      end
    end
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    check("ready_seen", 32'(got), 32'd1);
    check("latency", lat, exp_lat);
    check("err", 32'(err_obs), 32'(exp_err));
    check("rdata", rd_obs, exp_rd);
    check("mem_we_cycles", we_cnt, (we && !exp_err) ? 1 : 0);
    check("other_port_quiet", 32'(other), 32'd0);
    @(negedge clk);
    check("idle_outputs", 32'({m0_ready, m1_ready, m0_err, m1_err, mem_we}) | m0_rdata | m1_rdata,
          32'd0);
  endtask

  // Both ports hold word-load requests; grants must alternate starting with m0
  task automatic tie_run(input int n, input logic [31:0] a0, input logic [31:0] a1);
    int k = 0;
    int t = 0;
    int last_t = -1;
    drive(1'b0, 1'b1, 1'b0, a0, 32'h0, 2'd2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, a1, 32'h0, 2'd2, 1'b0);
    while (k < n && t < 10 * n) begin
      @(negedge clk);
      t++;
      if (m0_ready || m1_ready) begin
        check("tie_single_ready", 32'(m0_ready & m1_ready), 32'd0);
        check("tie_order", 32'(m1_ready), k % 2);
        check("tie_rdata", m1_ready ? m1_rdata : m0_rdata, ref_word(int'(m1_ready ? a1 : a0) / 4));
        if (last_t >= 0) check("tie_gap", t - last_t, 3);
        last_t = t;
        k++;
      end
    end
    check("tie_count", k, n);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_flags", 32'({m0_ready, m1_ready, m0_err, m1_err, mem_we}), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_rdata", m0_rdata | m1_rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests straight out of reset: m0 first, no starvation
    tie_run(20, 32'h10, 32'h20);

    // Word store then word load
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
    check("word4_after_store", ram[4], 32'hDEADBEEF);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0);

    // Byte RMW and byte loads
    txn(1'b0, 1'b1, 32'h12, 32'h0000005A, 2'd0, 1'b0);
    check("word4_after_byte", ram[4], 32'hDE5ABEEF);
    txn(1'b0, 1'b0, 32'h12, 32'h0, 2'd0, 1'b0);
    txn(1'b0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
    txn(1'b0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1);

    // Half RMW and half loads
    txn(1'b1, 1'b1, 32'h16, 32'h00008001, 2'd1, 1'b0);
    check("word5_after_half", ram[5], 32'h80010000);
    txn(1'b1, 1'b0, 32'h16, 32'h0, 2'd1, 1'b0);
    txn(1'b0, 1'b0, 32'h16, 32'h0, 2'd1, 1'b1);

    // Error cases: misaligned word, misaligned half store, illegal size, out of range
    txn(1'b0, 1'b0, 32'h02, 32'h0, 2'd2, 1'b0);
    txn(1'b0, 1'b1, 32'h03, 32'h1234, 2'd1, 1'b0);
    txn(1'b1, 1'b1, 32'h08, 32'hFFFFFFFF, 2'd3, 1'b0);
    txn(1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 2'd2, 1'b0);
    check("word0_no_alias_write", ram[0], ref_word(0));

    // Random traffic over the first 16 words with occasional out-of-range addresses
    for (int i = 0; i < 60; i++) begin
      bit          p, w, u;
      logic [1:0]  sz;
      logic [31:0] a, d;
      int          r;
      p  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = 32'($urandom_range(0, 63));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 15) == 0) a = a | (32'h400 << $urandom_range(0, 21));
      d  = $urandom();
      txn(p, w, a, d, sz, u);
    end

    // Reset during the write phase of a byte RMW: nothing reaches the RAM
    drive(1'b0, 1'b1, 1'b1, 32'h11, 32'h00000077, 2'd0, 1'b0);
    @(negedge clk);
    check("rmw_rd_no_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("rmw_wr_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_drops_we", 32'(mem_we), 32'd0);
    check("reset_no_ready", 32'({m0_ready, m1_ready}), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_word_kept", ram[4], ref_word(4));
    tie_run(4, 32'h10, 32'h14);

    for (int wi = 0; wi < 16; wi++) check("final_ram", ram[wi], ref_word(wi));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter_ctrl.md
Name: dmem_arbiter_ctrl

Overview:
- Sequences and shares the word-wide single-port data RAM between two requesters: port 0 (CPU load/store unit) and port 1 (debug/program loader).
- Converts byte/half/word loads and stores at any legal byte address into word accesses. Sub-word stores become read-modify-write, so neighbouring bytes are preserved.
- Performs lane extraction and sign/zero extension for loads.
- Sits between the CPU/loader and the RAM's word port. The RAM sees only full-word reads (combinational) and full-word writes (clocked).

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM; word address width = $clog2(DEPTH).
- AW, $clog2(DEPTH), derived width of mem_addr; not overridden by instantiators.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- m0_req, m1_req  in  1  request; held high until the matching mN_ready pulse
- m0_we, m1_we  in  1  1 = store, 0 = load
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- m0_size, m1_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- m0_unsigned, m1_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- m0_ready, m1_ready  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  32  load result, valid only while mN_ready=1, otherwise 0
- m0_err, m1_err  out  1  valid with mN_ready; misaligned, illegal size, or out-of-range
- mem_we  out  1  RAM word write enable
- mem_addr  out  AW  RAM word address
- mem_wdata  out  32  RAM word write data
- mem_rdata  in  32  RAM combinational read data for mem_addr

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE; all mN_ready, mN_err, mem_we = 0.
  - mem_addr, mem_wdata, mN_rdata = 0.
  - last_grant = 1, so port 0 wins the first tie.
- FSM states are IDLE, RD, WR and RESP.
- IDLE:
  - Arbitration:
    - If only one req is high, grant it.
    - If both are high, grant the port not equal to last_grant (round-robin).
    - Update last_grant on every grant.
  - On grant, latch id, we, addr, wdata, size and unsigned into request registers.
  - Error check:
    - size = 11 is an error.
    - half with addr[0] = 1 is an error.
    - word with addr[1:0] != 0 is an error.
    - addr[31:2] >= DEPTH is an error.
  - Next state:
    - Any error: go to RESP with err = 1.
    - Load or sub-word store: go to RD.
    - Word store: go to WR.
  - No request: stay in IDLE with mem_we = 0.
- RD:
  - Drive mem_addr = latched addr[AW+1:2].
  - Capture mem_rdata into word_q.
  - Next state: load goes to RESP; store goes to WR.
- WR:
  - mem_we = 1 for exactly one cycle; mem_addr = latched word address.
  - mem_wdata:
    - word store: wdata.
    - byte store: word_q with lane addr[1:0] replaced by wdata[7:0].
    - half store: word_q with half addr[1] replaced by wdata[15:0].
  - Next state: RESP.
- RESP:
  - Granted port gets ready = 1 and err, for one cycle. The other port's outputs stay 0.
  - Load rdata:
    - Select byte lane addr[1:0] or half lane addr[1] from word_q.
    - Extend per unsigned; word loads pass through unchanged.
    - Stores and errors return rdata = 0.
  - Next state: IDLE.
- Latency, counted from the req-sampled IDLE cycle N:
  - error: ready at N+1.
  - load and word store: ready at N+2.
  - sub-word store: ready at N+3.
  - A new grant is possible in the cycle after RESP.
- Rules:
  - Requests are not re-sampled after grant; a requester changing inputs mid-transaction has no effect.
  - A dropped req is a protocol violation; the transaction still completes, including its write.
  - The non-granted requester waits with req held and sees no ready.
  - Errored stores never assert mem_we.
  - Reset asserted mid-transaction returns to IDLE immediately and mem_we drops asynchronously. A partially sequenced RMW writes nothing; the RAM keeps its prior word.
- Width rules: mem_addr takes addr bits [AW+1:2]. The range check uses all of addr[31:2], so addresses that alias in the low bits are still errors.

Decomposition:
- Shared package dmem_pkg holds:
  - size_e {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10}.
  - state_e {IDLE, RD, WR, RESP}.
  - a request struct (we, addr, wdata, size, unsigned).
- One combinational sub-module, dmem_lane_align, does store-lane merge and load extract/extend. Inputs: word, wdata, addr[1:0], size, unsigned. Outputs: merged word, load result. It is reusable by the RAM's own read path.

Test Plan:
- Word store m0 addr 0x10 data 0xDEADBEEF, then word load at 0x10 -> mem_we one cycle, word 4 = 0xDEADBEEF; load m0_rdata = 0xDEADBEEF; each ready at N+2.
- With word 4 = 0xDEADBEEF, byte store 0x5A at 0x12 -> RD then WR, word 4 = 0xDE5ABEEF, ready at N+3. Then signed byte load 0x12 -> 0x0000005A; signed byte load 0x13 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
- Half store 0x8001 at 0x16 over word 5 = 0 -> word 5 = 0x80010000. Signed half load 0x16 -> 0xFFFF8001; unsigned -> 0x00008001.
- Both req in the same cycle from reset -> m0 granted first, m1 granted in the cycle after m0_ready. A further tie grants m0 again; m1 never starves across 10 back-to-back ties.
- Each case below gives err = 1 with ready at N+1 and no mem_we: word load 0x02, half store 0x03, size 11, addr 0x400 with DEPTH = 256.
- Assert reset_n low during WR of a byte store -> mem_we drops immediately, state IDLE, word unchanged. After release, m0 wins the first tie.
